// File: rtl/ili9488_pkg.sv
// rtl/ili9488_pkg.sv - shared constants, state encoding and helpers for the ILI9488 read engine
package ili9488_pkg;

    // Panel read commands
    localparam logic [7:0] RDDID = 8'h04;
    localparam logic [7:0] RDDST = 8'h09;
    localparam logic [7:0] RDDPM = 8'h0A;
    localparam logic [7:0] RDID1 = 8'hDA;
    localparam logic [7:0] RDID2 = 8'hDB;
    localparam logic [7:0] RDID3 = 8'hDC;

    // Default phase lengths in clk cycles
    localparam int WR_CYC_DEF      = 2;
    localparam int RD_LOW_CYC_DEF  = 8;
    localparam int RD_HIGH_CYC_DEF = 4;

    // Phase timer width; phase lengths must fit in this many bits
    localparam int TIMER_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_CMD_SETUP,
        ST_WR_LOW,
        ST_WR_HIGH,
        ST_TURN,
        ST_RD_LOW,
        ST_RD_HIGH,
        ST_RELEASE
    } rd_state_e;

    // At most four parameter bytes fit in rdata
    function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage

// File: rtl/ili9488_rd_engine_if.sv
// rtl/ili9488_rd_engine_if.sv - host handshake, bus arbitration and panel pin bundle
interface ili9488_rd_engine_if;
    logic        start;
    logic [7:0]  cmd;
    logic [2:0]  nbytes;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_gnt;
    logic        lcd_cs_n;
    logic        lcd_dc;
    logic        lcd_wr_n;
    logic        lcd_rd_n;
    logic [7:0]  lcd_db_out;
    logic        lcd_db_oe;
    logic [7:0]  lcd_db_in;

    // Engine side
    modport master (
        input  start, cmd, nbytes, bus_gnt, lcd_db_in,
        output busy, done, rdata, bus_req,
        output lcd_cs_n, lcd_dc, lcd_wr_n, lcd_rd_n, lcd_db_out, lcd_db_oe
    );

    // Host / multiplexer / panel side
    modport slave (
        output start, cmd, nbytes, bus_gnt, lcd_db_in,
        input  busy, done, rdata, bus_req,
        input  lcd_cs_n, lcd_dc, lcd_wr_n, lcd_rd_n, lcd_db_out, lcd_db_oe
    );
endinterface

// File: rtl/ili9488_phase_timer.sv
// rtl/ili9488_phase_timer.sv - loadable down-counter timing WRX/RDX phases
import ili9488_pkg::*;

module ili9488_phase_timer #(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Load N-1 to time an N-cycle phase; count saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/ili9488_rd_engine.sv
// rtl/ili9488_rd_engine.sv - ILI9488 8080-bus read engine: command, turnaround, dummy and parameter reads
import ili9488_pkg::*;

module ili9488_rd_engine #(
    parameter int WR_CYC      = WR_CYC_DEF,
    parameter int RD_LOW_CYC  = RD_LOW_CYC_DEF,
    parameter int RD_HIGH_CYC = RD_HIGH_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ili9488_rd_engine_if.master   bus
);

    localparam logic [TIMER_W-1:0] WR_LD = TIMER_W'(WR_CYC - 1);
    localparam logic [TIMER_W-1:0] RL_LD = TIMER_W'(RD_LOW_CYC - 1);
    localparam logic [TIMER_W-1:0] RH_LD = TIMER_W'(RD_HIGH_CYC - 1);

    rd_state_e            state;
    logic [7:0]           cmd_q;
    logic [2:0]           nbytes_q;
    logic [2:0]           rd_left;
    logic                 dummy_q;
    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_val;
    logic                 tmr_tc;

    ili9488_phase_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Reload the timer on every edge that enters a timed phase
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = WR_LD;
        case (state)
            ST_CMD_SETUP: begin
                tmr_load = 1'b1;
                tmr_val  = WR_LD;
            end
            ST_WR_LOW: begin
                tmr_load = tmr_tc;
                tmr_val  = WR_LD;
            end
            ST_TURN: begin
                tmr_load = 1'b1;
                tmr_val  = RL_LD;
            end
            ST_RD_LOW: begin
                tmr_load = tmr_tc;
                tmr_val  = RH_LD;
            end
            ST_RD_HIGH: begin
                tmr_load = tmr_tc;
                tmr_val  = RL_LD;
            end
            default: ;
        endcase
    end

    // Sequencer; pin values are registered together with the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cmd_q          <= 8'h00;
            nbytes_q       <= 3'd0;
            rd_left        <= 3'd0;
            dummy_q        <= 1'b0;
            bus.rdata      <= 32'h0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.bus_req    <= 1'b0;
            bus.lcd_cs_n   <= 1'b1;
            bus.lcd_dc     <= 1'b1;
            bus.lcd_wr_n   <= 1'b1;
            bus.lcd_rd_n   <= 1'b1;
            bus.lcd_db_oe  <= 1'b0;
            bus.lcd_db_out <= 8'h00;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cmd_q       <= bus.cmd;
                        nbytes_q    <= clamp_nbytes(bus.nbytes);
                        bus.rdata   <= 32'h0;
                        bus.busy    <= 1'b1;
                        bus.bus_req <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_gnt) begin
                        bus.lcd_cs_n   <= 1'b0;
                        bus.lcd_dc     <= 1'b0;
                        bus.lcd_db_oe  <= 1'b1;
                        bus.lcd_db_out <= cmd_q;
                        state          <= ST_CMD_SETUP;
                    end
                end
                ST_CMD_SETUP: begin
                    bus.lcd_wr_n <= 1'b0;
                    state        <= ST_WR_LOW;
                end
                ST_WR_LOW: begin
                    if (tmr_tc) begin
                        bus.lcd_wr_n <= 1'b1;
                        state        <= ST_WR_HIGH;
                    end
                end
                ST_WR_HIGH: begin
                    if (tmr_tc) begin
                        bus.lcd_db_oe <= 1'b0;
                        bus.lcd_dc    <= 1'b1;
                        rd_left       <= nbytes_q + 3'd1;
                        dummy_q       <= 1'b1;
                        state         <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    if (nbytes_q == 3'd0) begin
                        bus.lcd_cs_n <= 1'b1;
                        bus.bus_req  <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= ST_RELEASE;
                    end else begin
                        bus.lcd_rd_n <= 1'b0;
                        state        <= ST_RD_LOW;
                    end
                end
                ST_RD_LOW: begin
                    if (tmr_tc) begin
                        // First byte after the command is the dummy and is dropped
                        if (!dummy_q) begin
                            bus.rdata <= {bus.rdata[23:0], bus.lcd_db_in};
                        end
                        dummy_q      <= 1'b0;
                        rd_left      <= rd_left - 3'd1;
                        bus.lcd_rd_n <= 1'b1;
                        state        <= ST_RD_HIGH;
                    end
                end
                ST_RD_HIGH: begin
                    if (tmr_tc) begin
                        if (rd_left == 3'd0) begin
                            bus.lcd_cs_n <= 1'b1;
                            bus.bus_req  <= 1'b0;
                            bus.done     <= 1'b1;
                            state        <= ST_RELEASE;
                        end else begin
                            bus.lcd_rd_n <= 1'b0;
                            state        <= ST_RD_LOW;
                        end
                    end
                end
                ST_RELEASE: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ili9488_rd_engine.sv
// tb/tb_ili9488_rd_engine.sv - self-checking bench for ili9488_rd_engine
import ili9488_pkg::*;

module tb_ili9488_rd_engine;

    localparam int W = 2;
    localparam int L = 8;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ili9488_rd_engine_if bus();

    ili9488_rd_engine #(.WR_CYC(W), .RD_LOW_CYC(L), .RD_HIGH_CYC(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Panel model: drives the byte for each RDX pulse and watches pin rules
    logic [7:0]  db_drv = 8'h00;
    logic [39:0] cur_bytes = 40'h0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          viol = 0;
    int          rd_base = 0;
    int          mon_idx;
    logic [7:0]  cmd_seen = 8'h00;
    logic        prev_rd = 1'b1;
    logic        prev_wr = 1'b1;

    assign bus.lcd_db_in = db_drv;

    always @(negedge clk) begin
        if (bus.lcd_rd_n === 1'b0 && prev_rd === 1'b1) begin
            mon_idx = rd_pulses - rd_base;
            if (mon_idx >= 0 && mon_idx < 5) db_drv = cur_bytes[8*mon_idx +: 8];
            else db_drv = 8'hEE;
            rd_pulses++;
        end
        if (bus.lcd_wr_n === 1'b0 && prev_wr === 1'b1) wr_pulses++;
        if (bus.lcd_wr_n === 1'b0) begin
            cmd_seen = bus.lcd_db_out;
            if (bus.lcd_dc !== 1'b0 || bus.lcd_db_oe !== 1'b1 || bus.lcd_cs_n !== 1'b0) viol++;
        end
        if (bus.lcd_rd_n === 1'b0 &&
            (bus.lcd_db_oe !== 1'b0 || bus.lcd_cs_n !== 1'b0 || bus.lcd_dc !== 1'b1)) viol++;
        if (bus.lcd_wr_n === 1'b0 && bus.lcd_rd_n === 1'b0) viol++;
        prev_rd = bus.lcd_rd_n;
        prev_wr = bus.lcd_wr_n;
    end

    // Reference model: what a read should return and how long it takes
    function automatic logic [31:0] model_rdata(input logic [2:0] nb, input logic [39:0] bytes);
        int n;
        logic [31:0] r;
        n = (nb > 3'd4) ? 4 : int'(nb);
        r = 32'h0;
        for (int k = 1; k <= n; k++) r = (r << 8) | 32'(bytes[8*k +: 8]);
        return r;
    endfunction

    function automatic int model_pulses(input logic [2:0] nb);
        int n;
        n = (nb > 3'd4) ? 4 : int'(nb);
        return (n == 0) ? 0 : n + 1;
    endfunction

    function automatic int model_lat(input logic [2:0] nb);
        int n;
        n = (nb > 3'd4) ? 4 : int'(nb);
        return 1 + 2*W + 1 + ((n == 0) ? 0 : (n + 1) * (L + H)) + 1;
    endfunction

    task automatic run_txn(input string nm, input logic [7:0] c, input logic [2:0] nb,
                           input logic [39:0] bytes, input int gdelay, input bit bstart,
                           input logic [31:0] exp_rd, input int exp_pulses, input int exp_lat);
        int lat;
        int rd0;
        int wr0;
        int v0;
        bit wait_bad;
        logic [31:0] rd_done;
        @(negedge clk);
        cur_bytes   = bytes;
        rd_base     = rd_pulses;
        rd0         = rd_pulses;
        wr0         = wr_pulses;
        v0          = viol;
        bus.bus_gnt = 1'b0;
        bus.start   = 1'b1;
        bus.cmd     = c;
        bus.nbytes  = nb;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cmd    = 8'($urandom);
        bus.nbytes = 3'($urandom);
        chk({nm, "_req"}, 32'(bus.bus_req), 32'd1);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
        wait_bad = 1'b0;
        repeat (gdelay) begin
            @(negedge clk);
            if (bus.bus_req !== 1'b1 || bus.lcd_cs_n !== 1'b1) wait_bad = 1'b1;
        end
        if (gdelay > 0) chk({nm, "_wait"}, 32'(wait_bad), 32'd0);
        bus.bus_gnt = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bstart && lat == 10) begin
                bus.start  = 1'b1;
                bus.cmd    = 8'hFF;
                bus.nbytes = 3'd1;
            end else begin
                bus.start = 1'b0;
            end
        end while (bus.done !== 1'b1 && lat < 300);
        rd_done = bus.rdata;
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_rdata"}, rd_done, exp_rd);
        chk({nm, "_cs_rel"}, 32'(bus.lcd_cs_n), 32'd1);
        chk({nm, "_req_rel"}, 32'(bus.bus_req), 32'd0);
        chk({nm, "_rdpulses"}, rd_pulses - rd0, exp_pulses);
        chk({nm, "_wrpulses"}, wr_pulses - wr0, 32'd1);
        chk({nm, "_cmd"}, 32'(cmd_seen), 32'(c));
        chk({nm, "_pins"}, viol - v0, 32'd0);
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({nm, "_busy_end"}, 32'(bus.busy), 32'd0);
        chk({nm, "_hold"}, bus.rdata, exp_rd);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [2:0]  nb;
        logic [39:0] bytes;
        int          gdelay;
        bit          bstart;
        logic [31:0] exp_rdata;
        int          exp_pulses;
        int          exp_lat;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] cmds[6];

    initial begin
        logic [7:0]  rc;
        logic [2:0]  rnb;
        logic [39:0] rb;
        int          rg;
        int          guard;

        vecs[0] = '{RDDID, 3'd3, 40'h00_66_80_54_FF, 0,  1'b0, 32'h00548066, 4, 55};
        vecs[1] = '{RDDST, 3'd2, 40'h00_00_34_12_FF, 20, 1'b0, 32'h00001234, 3, 43};
        vecs[2] = '{RDDPM, 3'd0, 40'h00_00_00_00_00, 0,  1'b0, 32'h00000000, 0, 7};
        vecs[3] = '{RDID1, 3'd7, 40'h44_33_22_11_FF, 0,  1'b0, 32'h11223344, 5, 67};
        vecs[4] = '{RDID2, 3'd1, 40'h00_00_00_5A_FF, 0,  1'b1, 32'h0000005A, 2, 31};
        cmds    = '{RDDID, RDDST, RDDPM, RDID1, RDID2, RDID3};

        bus.start   = 1'b0;
        bus.cmd     = 8'h00;
        bus.nbytes  = 3'd0;
        bus.bus_gnt = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_cs_n", 32'(bus.lcd_cs_n), 32'd1);
        chk("rst_wr_n", 32'(bus.lcd_wr_n), 32'd1);
        chk("rst_rd_n", 32'(bus.lcd_rd_n), 32'd1);
        chk("rst_dc", 32'(bus.lcd_dc), 32'd1);
        chk("rst_oe", 32'(bus.lcd_db_oe), 32'd0);
        chk("rst_db_out", 32'(bus.lcd_db_out), 32'd0);
        chk("rst_req", 32'(bus.bus_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].nb, vecs[i].bytes,
                    vecs[i].gdelay, vecs[i].bstart, vecs[i].exp_rdata,
                    vecs[i].exp_pulses, vecs[i].exp_lat);
        end

        // Reset during the third RDX low phase
        @(negedge clk);
        cur_bytes   = 40'hD4_C3_B2_A1_FF;
        rd_base     = rd_pulses;
        bus.bus_gnt = 1'b1;
        bus.start   = 1'b1;
        bus.cmd     = RDID3;
        bus.nbytes  = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (!((rd_pulses - rd_base) == 3 && bus.lcd_rd_n === 1'b0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("rstmid_reach", 32'(guard < 200), 32'd1);
        chk("rstmid_partial", bus.rdata, 32'h000000A1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_rd_n", 32'(bus.lcd_rd_n), 32'd1);
        chk("rstmid_cs_n", 32'(bus.lcd_cs_n), 32'd1);
        chk("rstmid_req", 32'(bus.bus_req), 32'd0);
        chk("rstmid_rdata", bus.rdata, 32'd0);
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_oe", 32'(bus.lcd_db_oe), 32'd0);
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        rst_n = 1'b1;
        run_txn("after_rst", RDID3, 3'd4, 40'h04_03_02_01_FF, 1, 1'b0, 32'h01020304, 5, 67);

        // Randomized reads against the model
        for (int i = 0; i < 12; i++) begin
            rc  = cmds[$urandom_range(0, 5)];
            rnb = 3'($urandom_range(0, 7));
            rb  = {8'($urandom), 32'($urandom)};
            rg  = $urandom_range(0, 4);
            run_txn($sformatf("rnd%0d", i), rc, rnb, rb, rg, 1'($urandom_range(0, 1)),
                    model_rdata(rnb, rb), model_pulses(rnb), model_lat(rnb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
